// File: rtl/xcoef_pkg.sv
// -----------------------------------------------------------------------------
// xcoef_pkg
// Shared DSP definitions for the crosstalk-coefficient path.
//   COEF_ONE        : Q1.15 value closest to +1.0
//   COEF_IDENTITY   : complex element (+1.0, j0) packed as {real, imag}
//   COEF_*_LSB      : coefficient field slice positions (real [31:16], imag [15:0])
//   state_e         : control FSM states of the coefficient loader
// -----------------------------------------------------------------------------
package xcoef_pkg;

  localparam int COEF_W       = 32;
  localparam int COEF_FIELD_W = 16;
  localparam int COEF_RE_LSB  = 16;  // real part occupies [31:16]
  localparam int COEF_IM_LSB  = 0;   // imaginary part occupies [15:0]

  localparam logic [COEF_FIELD_W-1:0] COEF_ONE  = 16'h7FFF;
  localparam logic [COEF_FIELD_W-1:0] COEF_ZERO = 16'h0000;

  localparam logic [COEF_W-1:0] COEF_IDENTITY =
      (COEF_W'(COEF_ONE)  << COEF_RE_LSB) |
      (COEF_W'(COEF_ZERO) << COEF_IM_LSB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_e;

  // Identity-matrix element (i,j): +1.0 on the diagonal, zero elsewhere.
  function automatic logic [COEF_W-1:0] ident_elem(input int i, input int j);
    return (i == j) ? COEF_IDENTITY : '0;
  endfunction

endpackage

// File: rtl/xcoef_bank.sv
// -----------------------------------------------------------------------------
// xcoef_bank
// NDAC x NDAC matrix of 32-bit complex coefficients held in flops.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset (loads identity)
//   we_i           : single-element write enable, addressed by row_i/col_i
//   row_i, col_i   : element address for we_i (caller guarantees range)
//   data_i         : element write data
//   ident_i        : load identity into every element (highest priority)
//   load_i         : parallel load of the whole matrix from load_data_i
//   load_data_i    : flat matrix, element (i,j) at [(i*NDAC+j)*32 +: 32]
//   data_o         : flat matrix contents, same layout
// -----------------------------------------------------------------------------
module xcoef_bank
  import xcoef_pkg::*;
#(
  parameter int NDAC = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       we_i,
  input  logic [3:0]                 row_i,
  input  logic [3:0]                 col_i,
  input  logic [31:0]                data_i,
  input  logic                       ident_i,
  input  logic                       load_i,
  input  logic [NDAC*NDAC*32-1:0]    load_data_i,
  output logic [NDAC*NDAC*32-1:0]    data_o
);

  for (genvar gi = 0; gi < NDAC; gi++) begin : g_row
    for (genvar gj = 0; gj < NDAC; gj++) begin : g_col
      localparam int IDX = gi * NDAC + gj;

      logic [31:0] elem_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          elem_q <= ident_elem(gi, gj);
        end else if (ident_i) begin
          elem_q <= ident_elem(gi, gj);
        end else if (load_i) begin
          elem_q <= load_data_i[IDX*32 +: 32];
        end else if (we_i && (row_i == 4'(gi)) && (col_i == 4'(gj))) begin
          elem_q <= data_i;
        end
      end

      assign data_o[IDX*32 +: 32] = elem_q;
    end
  end

endmodule

// File: rtl/xcoef_loader.sv
// -----------------------------------------------------------------------------
// xcoef_loader
// Crosstalk-coefficient loader feeding the complex multiply-add stage.
// Host writes land in a shadow matrix; a commit arms a transfer that copies
// the whole shadow matrix into the active bank in a single edge, one cycle
// after the next frame-boundary strobe.
// Ports:
//   clk, rstn              : DSP clock, asynchronous active-low reset
//   wr_valid/wr_ready      : coefficient write handshake
//   wr_row, wr_col, wr_data: write address and {real, imag} Q1.15 data
//   commit                 : arm a shadow->active transfer (sampled in IDLE)
//   clear                  : reload identity into the shadow (IDLE only)
//   frame_stb              : frame boundary; only point the active bank moves
//   coef                   : active matrix, element (i,j) at [(i*NDAC+j)*32 +: 32]
//   commit_done            : one-cycle pulse after the active bank changed
//   armed                  : a commit is pending
//   cfg_gen                : number of applied commits (wraps)
//   addr_err               : sticky out-of-range write flag
//   rd_row, rd_col, rd_data: registered readback of the active bank
// -----------------------------------------------------------------------------
module xcoef_loader
  import xcoef_pkg::*;
#(
  parameter int NDAC = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [3:0]                 wr_row,
  input  logic [3:0]                 wr_col,
  input  logic [31:0]                wr_data,
  input  logic                       commit,
  input  logic                       clear,
  input  logic                       frame_stb,
  output logic [NDAC*NDAC*32-1:0]    coef,
  output logic                       commit_done,
  output logic                       armed,
  output logic [7:0]                 cfg_gen,
  output logic                       addr_err,
  input  logic [3:0]                 rd_row,
  input  logic [3:0]                 rd_col,
  output logic [31:0]                rd_data
);

  localparam int NE   = NDAC * NDAC;
  localparam int IDXW = (NE > 1) ? $clog2(NE) : 1;

  state_e state_q, state_d;

  logic        commit_done_q;
  logic [7:0]  cfg_gen_q;
  logic        addr_err_q;
  logic [31:0] rd_data_q;

  logic                 wr_accept;
  logic                 wr_in_range;
  logic                 clear_en;
  logic                 shadow_we;
  logic                 apply;
  logic [NE*32-1:0]     shadow_flat;
  logic [NE*32-1:0]     active_flat;

  // Row/col compared on 5 bits so NDAC = 16 still works.
  assign wr_in_range = ({1'b0, wr_row} < 5'(NDAC)) && ({1'b0, wr_col} < 5'(NDAC));
  assign wr_accept   = wr_valid && wr_ready;
  assign clear_en    = clear && (state_q == IDLE);
  // Clear overrides a simultaneous write; the write is still checked for range.
  assign shadow_we   = wr_accept && wr_in_range && !clear_en;
  assign apply       = (state_q == APPLY);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit)    state_d = ARMED;
      // frame_stb on the arming cycle itself is seen while still IDLE, so
      // the apply naturally waits for the following strobe.
      ARMED:   if (frame_stb) state_d = APPLY;
      APPLY:                  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  assign wr_ready = (state_q == IDLE);
  assign armed    = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Coefficient banks
  // ---------------------------------------------------------------------------
  xcoef_bank #(.NDAC(NDAC)) u_shadow (
    .clk         (clk),
    .rstn        (rstn),
    .we_i        (shadow_we),
    .row_i       (wr_row),
    .col_i       (wr_col),
    .data_i      (wr_data),
    .ident_i     (clear_en),
    .load_i      (1'b0),
    .load_data_i ('0),
    .data_o      (shadow_flat)
  );

  xcoef_bank #(.NDAC(NDAC)) u_active (
    .clk         (clk),
    .rstn        (rstn),
    .we_i        (1'b0),
    .row_i       (4'd0),
    .col_i       (4'd0),
    .data_i      (32'd0),
    .ident_i     (1'b0),
    .load_i      (apply),
    .load_data_i (shadow_flat),
    .data_o      (active_flat)
  );

  assign coef = active_flat;

  // ---------------------------------------------------------------------------
  // Flags and commit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      commit_done_q <= 1'b0;
      cfg_gen_q     <= 8'd0;
      addr_err_q    <= 1'b0;
    end else begin
      commit_done_q <= apply;
      if (apply) begin
        cfg_gen_q <= cfg_gen_q + 8'd1;
      end
      if (wr_accept && !wr_in_range) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign commit_done = commit_done_q;
  assign cfg_gen     = cfg_gen_q;
  assign addr_err    = addr_err_q;

  // ---------------------------------------------------------------------------
  // Readback of the active bank
  // ---------------------------------------------------------------------------
  logic [31:0]     active_arr [NE];
  logic            rd_in_range;
  logic [IDXW-1:0] rd_idx;
  logic [31:0]     rd_data_d;

  for (genvar gi = 0; gi < NE; gi++) begin : g_rd
    assign active_arr[gi] = active_flat[gi*32 +: 32];
  end

  assign rd_in_range = ({1'b0, rd_row} < 5'(NDAC)) && ({1'b0, rd_col} < 5'(NDAC));
  assign rd_idx      = IDXW'(int'(rd_row) * NDAC + int'(rd_col));

  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = active_arr[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_xcoef_loader.sv
// -----------------------------------------------------------------------------
// tb_xcoef_loader
// Directed bench for xcoef_loader with a reference model of the shadow and
// active matrices and a scoreboard queue for readback data.
// -----------------------------------------------------------------------------
module tb_xcoef_loader;

  localparam int NDAC = 4;
  localparam int NE   = NDAC * NDAC;

  logic              clk;
  logic              rstn;
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_row;
  logic [3:0]        wr_col;
  logic [31:0]       wr_data;
  logic              commit;
  logic              clear;
  logic              frame_stb;
  logic [NE*32-1:0]  coef;
  logic              commit_done;
  logic              armed;
  logic [7:0]        cfg_gen;
  logic              addr_err;
  logic [3:0]        rd_row;
  logic [3:0]        rd_col;
  logic [31:0]       rd_data;

  xcoef_loader #(.NDAC(NDAC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .commit      (commit),
    .clear       (clear),
    .frame_stb   (frame_stb),
    .coef        (coef),
    .commit_done (commit_done),
    .armed       (armed),
    .cfg_gen     (cfg_gen),
    .addr_err    (addr_err),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_shadow [NE];
  logic [31:0] m_active [NE];
  logic [7:0]  m_gen;
  int          exp_done;
  int          done_cnt = 0;
  logic [31:0] sb_q [$];

  // commit_done pulses are counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (commit_done === 1'b1) done_cnt++;
  end

  function automatic logic [31:0] ident(input int e);
    return ((e / NDAC) == (e % NDAC)) ? 32'h7FFF_0000 : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_coef(input string tag);
    for (int e = 0; e < NE; e++) begin
      chk($sformatf("%s_coef[%0d]", tag, e), coef[e*32 +: 32], m_active[e]);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin
      m_shadow[e] = ident(e);
      m_active[e] = ident(e);
    end
    m_gen = 8'd0;
  endtask

  task automatic model_apply();
    for (int e = 0; e < NE; e++) m_active[e] = m_shadow[e];
    m_gen = m_gen + 8'd1;
    exp_done++;
  endtask

  // One-cycle write; 'accept' is the bench's own knowledge of the FSM state.
  task automatic do_write(input int r, input int c, input logic [31:0] d, input bit accept);
    chk("wr_ready", 32'(wr_ready), 32'(accept));
    wr_valid = 1'b1;
    wr_row   = 4'(r);
    wr_col   = 4'(c);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    if (accept && r < NDAC && c < NDAC) m_shadow[r*NDAC + c] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_frame();
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
  endtask

  // frame_stb sampled at edge u, active bank loads at u+1, then one more cycle.
  task automatic do_apply_seq();
    do_frame();
    tick();
    model_apply();
    tick();
  endtask

  task automatic rd_check(input int r, input int c);
    logic [31:0] got;
    rd_row = 4'(r);
    rd_col = 4'(c);
    sb_q.push_back((r < NDAC && c < NDAC) ? m_active[r*NDAC + c] : 32'h0);
    tick();
    got = sb_q.pop_front();
    chk($sformatf("rd_data(%0d,%0d)", r, c), rd_data, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    commit = 1'b0; clear = 1'b0; frame_stb = 1'b0; rd_row = '0; rd_col = '0;
    exp_done = 0;
    model_reset();
    #2 rstn = 1'b0;
    tick(); tick();

    // Reset state
    chk_coef("reset");
    chk("reset_cfg_gen", 32'(cfg_gen), 32'h0);
    chk("reset_wr_ready", 32'(wr_ready), 32'h1);
    chk("reset_armed", 32'(armed), 32'h0);
    chk("reset_commit_done", 32'(commit_done), 32'h0);
    chk("reset_addr_err", 32'(addr_err), 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    rstn = 1'b1;
    tick();

    // Basic write / commit / frame_stb with latency check
    do_write(1, 2, 32'h1234_0056, 1'b1);
    do_commit();
    chk("armed_after_commit", 32'(armed), 32'h1);
    chk("wr_ready_armed", 32'(wr_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("coef12_hold", coef[6*32 +: 32], 32'h0);
    end
    do_frame();
    chk("coef12_at_u", coef[6*32 +: 32], 32'h0);
    chk("armed_apply", 32'(armed), 32'h1);
    tick();
    model_apply();
    chk_coef("apply1");
    chk("cfg_gen_1", 32'(cfg_gen), 32'(m_gen));
    chk("commit_done_pulse", 32'(commit_done), 32'h1);
    tick();
    chk("commit_done_low", 32'(commit_done), 32'h0);
    chk("armed_cleared", 32'(armed), 32'h0);
    chk("wr_ready_back", 32'(wr_ready), 32'h1);
    chk("done_cnt_1", 32'(done_cnt), 32'(exp_done));
    rd_check(1, 2);
    rd_check(0, 0);

    // Writes and a second commit while ARMED are ignored
    do_commit();
    do_write(2, 3, 32'hAAAA_5555, 1'b0);
    do_commit();
    tick();
    do_apply_seq();
    chk_coef("armed_ignore");
    chk("cfg_gen_2", 32'(cfg_gen), 32'(m_gen));
    tick(); tick();
    do_frame();
    tick(); tick();
    chk("cfg_gen_no_extra", 32'(cfg_gen), 32'(m_gen));
    chk("done_cnt_2", 32'(done_cnt), 32'(exp_done));

    // Write + commit + frame_stb on the same cycle: write included, no apply yet
    wr_valid = 1'b1; wr_row = 4'd0; wr_col = 4'd3; wr_data = 32'h0001_7FFF;
    commit = 1'b1; frame_stb = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0; frame_stb = 1'b0;
    m_shadow[3] = 32'h0001_7FFF;
    tick(); tick();
    chk("same_cycle_armed", 32'(armed), 32'h1);
    chk("same_cycle_no_apply", 32'(cfg_gen), 32'(m_gen));
    chk("same_cycle_coef03", coef[3*32 +: 32], 32'h0);
    do_apply_seq();
    chk_coef("same_cycle_apply");
    chk("cfg_gen_3", 32'(cfg_gen), 32'(m_gen));

    // Out-of-range write
    do_write(NDAC, 0, 32'hFFFF_FFFF, 1'b1);
    chk("addr_err_set", 32'(addr_err), 32'h1);
    do_commit();
    do_apply_seq();
    chk_coef("oor_apply");
    rd_check(NDAC, 0);
    rd_check(0, 3);
    chk("addr_err_sticky", 32'(addr_err), 32'h1);

    // Clear wins over a simultaneous write
    wr_valid = 1'b1; wr_row = 4'd0; wr_col = 4'd0; wr_data = 32'h0000_0005;
    clear = 1'b1;
    tick();
    wr_valid = 1'b0; clear = 1'b0;
    for (int e = 0; e < NE; e++) m_shadow[e] = ident(e);
    do_commit();
    do_apply_seq();
    chk_coef("clear_apply");

    // Reset while ARMED
    do_write(2, 2, 32'hDEAD_BEEF, 1'b1);
    do_commit();
    do_apply_seq();
    chk_coef("pre_reset");
    do_write(3, 3, 32'h0BAD_F00D, 1'b1);
    do_commit();
    chk("armed_before_reset", 32'(armed), 32'h1);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async_armed", 32'(armed), 32'h0);
    chk("async_cfg_gen", 32'(cfg_gen), 32'h0);
    chk("async_addr_err", 32'(addr_err), 32'h0);
    chk("async_rd_data", rd_data, 32'h0);
    chk_coef("async_reset");
    rstn = 1'b1;
    tick();
    do_frame();
    tick(); tick();
    chk("post_reset_no_done", 32'(done_cnt), 32'(exp_done));
    chk("post_reset_cfg_gen", 32'(cfg_gen), 32'h0);
    chk_coef("post_reset");

    // 256 commits wrap cfg_gen back to zero
    for (int n = 0; n < 256; n++) begin
      do_commit();
      do_apply_seq();
    end
    chk("wrap_cfg_gen", 32'(cfg_gen), 32'(m_gen));
    chk("wrap_cfg_gen_zero", 32'(cfg_gen), 32'h0);
    chk("wrap_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk_coef("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcoef_loader.md
# xcoef_loader

Crosstalk-coefficient loader sitting directly upstream of the complex matrix multiply-add stage. It accepts host writes of complex Q1.15 coefficients into a shadow matrix. On a commit request it atomically transfers the whole matrix to the active coefficient bank at the next frame boundary, so the downstream stage never sees a partially updated matrix. After reset the active bank is the identity matrix, so the DSP chain passes samples straight through.

## Interface

Parameters:
- NDAC, 4, matrix dimension (number of DAC channels), 1..16.

Ports:
- clk  in  1  DSP clock, same clock as the multiply-add stage.
- rstn  in  1  asynchronous active-low reset.
- wr_valid  in  1  coefficient write request.
- wr_ready  out  1  loader can accept a write.
- wr_row  in  4  row index i.
- wr_col  in  4  column index j.
- wr_data  in  32  coefficient; [31:16] = real, [15:0] = imag, signed Q1.15.
- commit  in  1  single-cycle request to apply the shadow matrix.
- clear  in  1  single-cycle request to load identity into the shadow matrix.
- frame_stb  in  1  frame-boundary strobe; this is the only cycle on which the active bank may change.
- coef  out  NDAC*NDAC*32  active matrix; element (i,j) at bits [(i*NDAC+j)*32 +: 32]. Wired to the coef[i][j] field of the DSP interface.
- commit_done  out  1  one-cycle pulse on the cycle after the active bank changes.
- armed  out  1  a commit is pending.
- cfg_gen  out  8  count of applied commits.
- addr_err  out  1  sticky flag: an out-of-range write was attempted.
- rd_row, rd_col  in  4 each  readback address into the active bank.
- rd_data  out  32  readback data, one-cycle latency.

## Operation

- Identity element: diagonal = 0x7FFF_0000 (+0.99997 + j0); off-diagonal = 0.
- Reset values:
  - shadow = identity, active (coef) = identity.
  - State IDLE, wr_ready = 1, armed = 0, commit_done = 0.
  - cfg_gen = 0, addr_err = 0, rd_data = 0.
- Write:
  - A write is accepted on a cycle where wr_valid && wr_ready are both high.
  - If wr_row < NDAC and wr_col < NDAC, shadow[row][col] = wr_data.
  - Otherwise the data is discarded and addr_err is set. addr_err stays set until reset.
- clear: all shadow elements become identity. If clear coincides with an accepted write, clear wins.
- States:
  - IDLE: wr_ready = 1. commit → ARMED.
  - ARMED: wr_ready = 0, armed = 1. frame_stb → APPLY. commit and clear are ignored.
  - APPLY (one cycle): active ← shadow (all NDAC² elements on the same edge), cfg_gen += 1 (wraps 255→0), commit_done = 1 on the following cycle, then → IDLE.
- A commit is only sampled in IDLE. A commit in the same cycle as an accepted write arms with that write included.
- A frame_stb in the same cycle as commit does not apply the matrix; the apply waits for the next frame_stb.
- The shadow matrix is never read by the downstream stage. Active elements that are not rewritten keep their values across commits, because the shadow retains its contents.
- Readback reads the active bank only. For an out-of-range rd_row or rd_col, rd_data = 0.

## Timing

- Write accepted at edge t → shadow updated at edge t; visible to a commit sampled at t+1 or later.
- commit sampled at edge t → armed = 1 from t (registered), wr_ready = 0 from t.
- First frame_stb sampled at edge u > t → state APPLY.
- Edge u+1: coef updates and cfg_gen increments; then:
  - commit_done is high for the cycle following u+1;
  - armed = 0 and wr_ready = 1 again.
- Latency from frame_stb to new coef at the outputs: 2 edges. Coefficient outputs are registers with no combinational path from the inputs.
- rd_data is registered: rd address at edge t → rd_data valid after edge t+1.
- Reset asserted mid-ARMED or mid-APPLY: the commit is abandoned immediately and all outputs take their reset values asynchronously.

## Structure

- Shared DSP package holds:
  - COEF_ONE = 16'h7FFF and the identity-element constant;
  - the coefficient field slice positions (real [31:16], imag [15:0]);
  - the state enum {IDLE, ARMED, APPLY}.
- One sub-module is natural: xcoef_bank, an NDAC×NDAC×32 register array with write-enable, identity load and parallel-load ports. It is instantiated twice (shadow, active).
- The control FSM, readback mux and flags live in the top module.

## Test plan

- After reset: coef equals identity (element (0,0) = 0x7FFF0000, element (0,1) = 0); cfg_gen = 0; wr_ready = 1.
- Write (1,2) = 0x12340056, commit, frame_stb 5 cycles later → coef (1,2) unchanged until the cycle after frame_stb's sampling edge, then 0x12340056; all other elements identity; commit_done pulses once; cfg_gen = 1.
- While ARMED, drive wr_valid with new data → wr_ready = 0, no shadow change; a second commit is ignored, and exactly one apply occurs.
- frame_stb in the same cycle as commit → no apply; the apply happens at the next frame_stb.
- Write (NDAC,0) = 0xFFFFFFFF → addr_err = 1 and stays set; no element changes after commit; rd_data for (NDAC,0) = 0.
- Reset pulsed while ARMED → coef identity, armed = 0; a subsequent frame_stb produces no commit_done; 256 commits wrap cfg_gen to 0.
